// File: rtl/rx_csum_align.sv
// Holds each RX frame until its checksum result arrives, then replays it with csum/status sideband.
// Optional: define RX_CSUM_DROP_EN to discard frames whose TCP/UDP checksum failed.
module rx_csum_align #(
  parameter int unsigned DATA_DEPTH     = 64,
  parameter int unsigned FRM_DEPTH      = 8,
  parameter int unsigned DMA_DATA_WIDTH = 256,
  parameter int unsigned DMA_KEEP_WIDTH = DMA_DATA_WIDTH / 8,
  parameter int unsigned CSUM_WIDTH     = 16,
  parameter int unsigned STATUS_WIDTH   = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_axis_valid,
  input  logic                      s_axis_last,
  input  logic [DMA_DATA_WIDTH-1:0] s_axis_data,
  input  logic [DMA_KEEP_WIDTH-1:0] s_axis_data_be,
  output logic                      s_axis_ready,
  input  logic                      csum_valid,
  input  logic [CSUM_WIDTH-1:0]     csum_data,
  input  logic [STATUS_WIDTH-1:0]   csum_status,
  output logic                      m_axis_valid,
  output logic                      m_axis_last,
  output logic [DMA_DATA_WIDTH-1:0] m_axis_data,
  output logic [DMA_KEEP_WIDTH-1:0] m_axis_data_be,
  input  logic                      m_axis_ready,
  output logic [CSUM_WIDTH-1:0]     m_axis_csum,
  output logic [STATUS_WIDTH-1:0]   m_axis_status,
  output logic                      orphan_err
);

  localparam int unsigned DataAw = $clog2(DATA_DEPTH);
  localparam int unsigned DataCw = DataAw + 1;
  localparam int unsigned FrmAw  = $clog2(FRM_DEPTH);
  localparam int unsigned FrmCw  = FrmAw + 1;
  localparam int unsigned BeatW  = 1 + DMA_KEEP_WIDTH + DMA_DATA_WIDTH;
  localparam int unsigned ResW   = CSUM_WIDTH + STATUS_WIDTH;

  localparam logic [DataCw-1:0] DataFull = DataCw'(DATA_DEPTH);
  localparam logic [FrmCw-1:0]  FrmFull  = FrmCw'(FRM_DEPTH);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StSend = 2'd1;
`ifdef RX_CSUM_DROP_EN
  localparam logic [1:0] StDrop = 2'd2;
`endif

  // Data FIFO storage: {last, be, data}
  logic [BeatW-1:0]  dmem [DATA_DEPTH];
  logic [DataAw-1:0] dwr_q, drd_q;
  logic [DataCw-1:0] dcnt_q, dcnt_d;

  // Result FIFO storage: {csum, status}
  logic [ResW-1:0]  rmem [FRM_DEPTH];
  logic [FrmAw-1:0] rwr_q, rrd_q;
  logic [FrmCw-1:0] rcnt_q, rcnt_d;

  logic [FrmCw-1:0] frm_open_q, frm_open_d;
  logic [FrmCw-1:0] frm_pend_q, frm_pend_d;
  logic             mid_q;
  logic [1:0]       state_q, state_d;
  logic [CSUM_WIDTH-1:0]   csum_q;
  logic [STATUS_WIDTH-1:0] status_q;
  logic             orphan_q;

  logic             d_full, d_empty, r_empty, pend_full;
  logic             in_acc, in_sof, in_eof;
  logic             res_push, res_pop, orphan_hit;
  logic             out_pop, pop_last, send;
  logic [BeatW-1:0] head;
  logic             head_last;
  logic [ResW-1:0]  res_head;

  assign d_full    = (dcnt_q == DataFull);
  assign d_empty   = (dcnt_q == '0);
  assign r_empty   = (rcnt_q == '0);
  assign pend_full = (frm_pend_q == FrmFull);

  // A frame already started may always finish; new frames need a pending slot.
  assign s_axis_ready = !rst && !d_full && (!pend_full || mid_q);

  assign in_acc = s_axis_valid & s_axis_ready;
  assign in_sof = in_acc & !mid_q;
  assign in_eof = in_acc & s_axis_last;

  assign res_push   = csum_valid & (frm_open_q != '0);
  assign orphan_hit = csum_valid & (frm_open_q == '0);
  assign res_pop    = (state_q == StIdle) & !r_empty;
  assign res_head   = rmem[rrd_q];

  assign head      = dmem[drd_q];
  assign head_last = head[BeatW-1];
  assign send      = (state_q == StSend);

`ifdef RX_CSUM_DROP_EN
  assign out_pop = ((send & m_axis_ready) | (state_q == StDrop)) & !d_empty;
`else
  assign out_pop = send & m_axis_ready & !d_empty;
`endif
  assign pop_last = out_pop & head_last;

  assign m_axis_valid   = send & !d_empty;
  assign m_axis_last    = m_axis_valid & head_last;
  assign m_axis_data    = m_axis_valid ? head[DMA_DATA_WIDTH-1:0] : '0;
  assign m_axis_data_be = m_axis_valid ? head[BeatW-2 -: DMA_KEEP_WIDTH] : '0;
  assign m_axis_csum    = csum_q;
  assign m_axis_status  = status_q;
  assign orphan_err     = orphan_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (res_pop) begin
`ifdef RX_CSUM_DROP_EN
          // status[4] = tcp_fail, status[3] = udp_fail
          if (res_head[4] || res_head[3]) state_d = StDrop;
          else                            state_d = StSend;
`else
          state_d = StSend;
`endif
        end
      end
      StSend: if (pop_last) state_d = StIdle;
`ifdef RX_CSUM_DROP_EN
      StDrop: if (pop_last) state_d = StIdle;
`endif
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    dcnt_d = dcnt_q;
    case ({in_acc, out_pop})
      2'b10:   dcnt_d = dcnt_q + 1'b1;
      2'b01:   dcnt_d = dcnt_q - 1'b1;
      default: dcnt_d = dcnt_q;
    endcase
  end

  always_comb begin
    rcnt_d = rcnt_q;
    case ({res_push, res_pop})
      2'b10:   rcnt_d = rcnt_q + 1'b1;
      2'b01:   rcnt_d = rcnt_q - 1'b1;
      default: rcnt_d = rcnt_q;
    endcase
  end

  always_comb begin
    frm_open_d = frm_open_q;
    case ({in_eof, res_push})
      2'b10:   frm_open_d = frm_open_q + 1'b1;
      2'b01:   frm_open_d = frm_open_q - 1'b1;
      default: frm_open_d = frm_open_q;
    endcase
  end

  always_comb begin
    frm_pend_d = frm_pend_q;
    case ({in_sof, pop_last})
      2'b10:   frm_pend_d = frm_pend_q + 1'b1;
      2'b01:   frm_pend_d = frm_pend_q - 1'b1;
      default: frm_pend_d = frm_pend_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (in_acc) dmem[dwr_q] <= {s_axis_last, s_axis_data_be, s_axis_data};
    if (res_push) rmem[rwr_q] <= {csum_data, csum_status};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dwr_q      <= '0;
      drd_q      <= '0;
      dcnt_q     <= '0;
      rwr_q      <= '0;
      rrd_q      <= '0;
      rcnt_q     <= '0;
      frm_open_q <= '0;
      frm_pend_q <= '0;
      mid_q      <= 1'b0;
      state_q    <= StIdle;
      csum_q     <= '0;
      status_q   <= '0;
      orphan_q   <= 1'b0;
    end else begin
      if (in_acc)   dwr_q <= dwr_q + 1'b1;
      if (out_pop)  drd_q <= drd_q + 1'b1;
      if (res_push) rwr_q <= rwr_q + 1'b1;
      if (res_pop) begin
        rrd_q    <= rrd_q + 1'b1;
        csum_q   <= res_head[ResW-1 -: CSUM_WIDTH];
        status_q <= res_head[STATUS_WIDTH-1:0];
      end
      if (in_acc)     mid_q <= !s_axis_last;
      if (orphan_hit) orphan_q <= 1'b1;
      dcnt_q     <= dcnt_d;
      rcnt_q     <= rcnt_d;
      frm_open_q <= frm_open_d;
      frm_pend_q <= frm_pend_d;
      state_q    <= state_d;
    end
  end

endmodule

// File: tb/tb_rx_csum_align.sv
// Self-checking bench for rx_csum_align: directed vector table, back-pressure, random traffic,
// orphan result and mid-frame reset.
module tb_rx_csum_align;

  localparam int unsigned DW = 256;
  localparam int unsigned KW = 32;
  localparam int unsigned CW = 16;
  localparam int unsigned SW = 5;
`ifdef RX_CSUM_DROP_EN
  localparam bit DropEn = 1'b1;
`else
  localparam bit DropEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          s_axis_valid, s_axis_last, s_axis_ready;
  logic [DW-1:0] s_axis_data;
  logic [KW-1:0] s_axis_data_be;
  logic          csum_valid;
  logic [CW-1:0] csum_data;
  logic [SW-1:0] csum_status;
  logic          m_axis_valid, m_axis_last, m_axis_ready;
  logic [DW-1:0] m_axis_data;
  logic [KW-1:0] m_axis_data_be;
  logic [CW-1:0] m_axis_csum;
  logic [SW-1:0] m_axis_status;
  logic          orphan_err;

  rx_csum_align dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_valid  (s_axis_valid),
    .s_axis_last   (s_axis_last),
    .s_axis_data   (s_axis_data),
    .s_axis_data_be(s_axis_data_be),
    .s_axis_ready  (s_axis_ready),
    .csum_valid    (csum_valid),
    .csum_data     (csum_data),
    .csum_status   (csum_status),
    .m_axis_valid  (m_axis_valid),
    .m_axis_last   (m_axis_last),
    .m_axis_data   (m_axis_data),
    .m_axis_data_be(m_axis_data_be),
    .m_axis_ready  (m_axis_ready),
    .m_axis_csum   (m_axis_csum),
    .m_axis_status (m_axis_status),
    .orphan_err    (orphan_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] be;
    logic          last;
    logic [CW-1:0] csum;
    logic [SW-1:0] st;
  } beat_t;

  typedef struct {
    logic [CW-1:0] csum;
    logic [SW-1:0] st;
    int            due;
  } res_t;

  typedef struct {
    int            n;
    logic [CW-1:0] csum;
    logic [SW-1:0] st;
    int            dly;
    bit            fwd;
  } vec_t;

  beat_t sb[$];
  res_t  csq[$];

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int out_beats = 0;
  int first_cyc = 0;
  int csum_cyc = 0;
  int last_due = 0;
  int rdy_mode = 1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void push_res(input logic [CW-1:0] c, input logic [SW-1:0] s, input int dly);
    int due;
    res_t r;
    due = cyc + dly - 1;
    if (due <= last_due) due = last_due + 1;
    last_due = due;
    r.csum = c;
    r.st   = s;
    r.due  = due;
    csq.push_back(r);
  endfunction

  // Downstream ready: 0 = held low, 1 = held high, otherwise random 50%
  initial begin
    m_axis_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_axis_ready = 1'b0;
        1:       m_axis_ready = 1'b1;
        default: m_axis_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Checksum engine model: one pulse per queued result once it falls due
  initial begin
    csum_valid  = 1'b0;
    csum_data   = '0;
    csum_status = '0;
    forever begin
      @(posedge clk);
      #1;
      csum_valid = 1'b0;
      if (csq.size() > 0 && csq[0].due <= cyc) begin
        csum_valid  = 1'b1;
        csum_data   = csq[0].csum;
        csum_status = csq[0].st;
        csum_cyc    = cyc;
        void'(csq.pop_front());
      end
    end
  end

  // Output monitor: scoreboard compare on handshake, stability check while stalled
  bit            hold = 1'b0;
  bit            in_frame = 1'b0;
  logic [DW-1:0] hold_data;
  logic [CW-1:0] hold_csum;
  logic          hold_last;

  always @(negedge clk) begin
    if (rst) begin
      hold     = 1'b0;
      in_frame = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_valid", DW'(m_axis_valid), DW'(1));
        chk("hold_data", m_axis_data, hold_data);
        chk("hold_side", DW'({m_axis_last, m_axis_csum}), DW'({hold_last, hold_csum}));
      end
      hold = 1'b0;
      if (m_axis_valid === 1'b1) begin
        if (m_axis_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_beat", DW'(1), DW'(0));
          end else begin
            beat_t e;
            e = sb.pop_front();
            chk("out_data", m_axis_data, e.data);
            chk("out_side", DW'({m_axis_last, m_axis_data_be, m_axis_csum, m_axis_status}),
                DW'({e.last, e.be, e.csum, e.st}));
          end
          out_beats++;
          if (!in_frame) first_cyc = cyc;
          in_frame = !m_axis_last;
        end else begin
          hold      = 1'b1;
          hold_data = m_axis_data;
          hold_csum = m_axis_csum;
          hold_last = m_axis_last;
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the last beat is accepted
  task automatic drive_frame(input int n, input logic [CW-1:0] c, input logic [SW-1:0] s,
                             input int dly, input bit fwd);
    beat_t         bt;
    logic [KW-1:0] ones;
    bit            acc;
    ones = '1;
    for (int b = 0; b < n; b++) begin
      for (int k = 0; k < DW / 32; k++) bt.data[k*32 +: 32] = $urandom();
      bt.last = (b == n - 1);
      bt.be   = bt.last ? (ones >> $urandom_range(0, KW - 1)) : ones;
      bt.csum = c;
      bt.st   = s;
      s_axis_valid   = 1'b1;
      s_axis_data    = bt.data;
      s_axis_data_be = bt.be;
      s_axis_last    = bt.last;
      acc = 1'b0;
      for (int w = 0; w < 2000 && !acc; w++) begin
        @(negedge clk);
        acc = s_axis_ready;
      end
      if (!acc) begin
        chk("in_accept_timeout", DW'(0), DW'(1));
        s_axis_valid = 1'b0;
        s_axis_last  = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      if (fwd) sb.push_back(bt);
    end
    s_axis_valid = 1'b0;
    s_axis_last  = 1'b0;
    push_res(c, s, dly);
  endtask

  task automatic wait_drain();
    int w;
    for (w = 0; w < 20000 && (sb.size() != 0 || csq.size() != 0); w++) @(negedge clk);
    if (sb.size() != 0 || csq.size() != 0) chk("drain_timeout", DW'(0), DW'(1));
    repeat (60) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  vec_t vt[6];

  initial begin
    int b0;
    rst            = 1'b1;
    s_axis_valid   = 1'b0;
    s_axis_last    = 1'b0;
    s_axis_data    = '0;
    s_axis_data_be = '0;

    vt[0] = '{3, 16'h0000, 5'b00101, 5, 1'b1};
    vt[1] = '{1, 16'h1234, 5'b00011, 4, 1'b1};
    vt[2] = '{4, 16'habcd, 5'b10101, 5, !DropEn};
    vt[3] = '{2, 16'h5555, 5'b00101, 3, 1'b1};
    vt[4] = '{3, 16'h0f0f, 5'b01011, 3, !DropEn};
    vt[5] = '{5, 16'hffff, 5'b00001, 7, 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", DW'(s_axis_ready), DW'(0));
    chk("rst_m_valid", DW'(m_axis_valid), DW'(0));
    chk("rst_m_data", m_axis_data, DW'(0));
    chk("rst_m_side", DW'({m_axis_last, m_axis_data_be, m_axis_csum, m_axis_status}), DW'(0));
    chk("rst_orphan", DW'(orphan_err), DW'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", DW'(s_axis_ready), DW'(1));
    @(posedge clk);
    #1;

    // Directed vector table, one frame at a time from an idle block
    rdy_mode = 1;
    for (int i = 0; i < 6; i++) begin
      b0 = out_beats;
      drive_frame(vt[i].n, vt[i].csum, vt[i].st, vt[i].dly, vt[i].fwd);
      wait_drain();
      chk($sformatf("vec%0d_beats", i), DW'(out_beats - b0), DW'(vt[i].fwd ? vt[i].n : 0));
      if (vt[i].fwd) chk($sformatf("vec%0d_latency", i), DW'(first_cyc - csum_cyc), DW'(2));
    end

    // Eight back-to-back frames with the output stalled
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) drive_frame(2, CW'(i + 1), 5'b00101, 6, 1'b1);
    repeat (20) @(negedge clk);
    chk("bp_s_ready", DW'(s_axis_ready), DW'(0));
    chk("bp_m_valid", DW'(m_axis_valid), DW'(1));
    chk("bp_m_csum", DW'(m_axis_csum), DW'(1));
    chk("bp_sb_depth", DW'(sb.size()), DW'(16));
    @(posedge clk);
    #1;
    rdy_mode = 1;
    wait_drain();
    chk("bp_ready_after", DW'(s_axis_ready), DW'(1));

    // Random lengths, statuses and downstream stalls
    rdy_mode = 2;
    b0 = out_beats;
    for (int i = 0; i < 100; i++) begin
      int            n;
      logic [SW-1:0] s;
      n = $urandom_range(1, 48);
      s = SW'($urandom_range(0, 31));
      drive_frame(n, CW'($urandom()), s, $urandom_range(2, 8), !(DropEn && (s[4] || s[3])));
    end
    rdy_mode = 1;
    wait_drain();
    chk("rand_sb_empty", DW'(sb.size()), DW'(0));

    // Orphan result with nothing in flight
    b0 = out_beats;
    push_res(16'h1111, 5'b00001, 3);
    repeat (10) @(negedge clk);
    chk("orphan_set", DW'(orphan_err), DW'(1));
    chk("orphan_no_out", DW'(out_beats - b0), DW'(0));

    // Reset while a frame is held at the output and another is mid-input
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    s_axis_valid   = 1'b1;
    s_axis_last    = 1'b0;
    s_axis_data    = DW'(256'h1234_5678);
    s_axis_data_be = '1;
    @(posedge clk);
    #1;
    s_axis_last = 1'b1;
    @(posedge clk);
    #1;
    s_axis_valid = 1'b0;
    s_axis_last  = 1'b0;
    push_res(16'hbeef, 5'b00111, 3);
    for (int w = 0; w < 50 && m_axis_valid !== 1'b1; w++) @(negedge clk);
    chk("pre_rst_valid", DW'(m_axis_valid), DW'(1));
    chk("pre_rst_csum", DW'(m_axis_csum), DW'(16'hbeef));
    @(posedge clk);
    #1;
    s_axis_valid = 1'b1;
    @(posedge clk);
    #1;
    s_axis_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("in_rst_s_ready", DW'(s_axis_ready), DW'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_m_valid", DW'(m_axis_valid), DW'(0));
    chk("post_rst_m_data", m_axis_data, DW'(0));
    chk("post_rst_m_side", DW'({m_axis_last, m_axis_data_be, m_axis_csum, m_axis_status}), DW'(0));
    chk("post_rst_orphan", DW'(orphan_err), DW'(0));
    chk("post_rst_s_ready", DW'(s_axis_ready), DW'(1));
    @(posedge clk);
    #1;
    rdy_mode = 1;
    b0 = out_beats;
    drive_frame(4, 16'h4242, 5'b00011, 4, 1'b1);
    wait_drain();
    chk("post_rst_frame_beats", DW'(out_beats - b0), DW'(4));
    chk("post_rst_orphan_clear", DW'(orphan_err), DW'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rx_csum_align.md
# rx_csum_align

Receive-side stage directly downstream of the Ethernet RX checksum engine. Frame beats from the MAC are accepted into a data FIFO at the same time as the checksum engine taps them. Each frame is held until its checksum result arrives (`csum_valid`/`csum_data`/`csum_status`, a few cycles after the frame's last beat). The frame is then replayed to the RoCE/NIC RX path with the 16-bit checksum and 5-bit status as per-frame sideband, optionally dropping frames whose TCP/UDP checksum failed.

## Interface
Parameters:
- `DATA_DEPTH`, 64: data FIFO depth in beats; power of two; must be ≥ max frame length in beats (1518 B = 48 beats at 256 bit).
- `FRM_DEPTH`, 8: maximum frames in flight, i.e. result FIFO depth; power of two.

Ports:
- `clk`  in  1  single clock for the whole block.
- `rst`  in  1  synchronous, active-high reset.
- `s_axis_valid`  in  1  input beat valid.
- `s_axis_last`  in  1  last beat of the frame.
- `s_axis_data`  in  `DMA_DATA_WIDTH`  frame data, byte 0 at bits [7:0].
- `s_axis_data_be`  in  `DMA_KEEP_WIDTH`  byte enables.
- `s_axis_ready`  out  1  beat accepted when `valid & ready`; this same handshake drives the checksum engine.
- `csum_valid`  in  1  one-cycle pulse carrying the result for the oldest unresolved frame.
- `csum_data`  in  `CSUM_WIDTH`  folded checksum.
- `csum_status`  in  `STATUS_WIDTH`  {tcp_fail, udp_fail, tcp, udp, ip}.
- `m_axis_valid`, `m_axis_last`, `m_axis_data`, `m_axis_data_be`  out  1/1/`DMA_DATA_WIDTH`/`DMA_KEEP_WIDTH`  output frame.
- `m_axis_ready`  in  1  downstream ready.
- `m_axis_csum`  out  `CSUM_WIDTH`  checksum of the current output frame; constant on all of its beats.
- `m_axis_status`  out  `STATUS_WIDTH`  status of the current output frame; constant on all of its beats.
- `orphan_err`  out  1  sticky flag: a `csum_valid` pulse arrived with no unresolved frame.

## Operation
- Data FIFO: every accepted input beat is written as {last, be, data}.
- Frame tracking:
  - `frm_open` counts frames whose last beat has been accepted but whose result has not yet arrived.
  - `frm_pend` counts frames accepted but not yet fully emitted or dropped, range 0..`FRM_DEPTH`.
- `s_axis_ready` = data FIFO not full AND (`frm_pend` < `FRM_DEPTH` OR the current input frame is already mid-frame).
- Result FIFO:
  - On `csum_valid` with `frm_open` > 0: push {csum, status} and decrement `frm_open`.
  - On `csum_valid` with `frm_open` = 0: discard the result and set `orphan_err`.
- Output FSM:
  - IDLE: when the result FIFO is non-empty, load the head result into the output sideband registers, pop the result, and go to SEND (or DROP, see Configuration).
  - SEND: present data FIFO head beats. Each `m_axis_valid & m_axis_ready` pops one beat. A popped beat with last=1 decrements `frm_pend` and returns to IDLE.
  - DROP: pop one beat per cycle with `m_axis_valid` = 0; the last beat decrements `frm_pend` and returns to IDLE.
- Result order equals frame order. A result only exists after its frame's last beat is buffered, so SEND never underruns.
- Simultaneous events:
  - FIFO push and pop in the same cycle are both honoured; occupancy is unchanged.
  - A `frm_open`/`frm_pend` increment and decrement in the same cycle leave the count unchanged.
  - `csum_valid` in the same cycle as the last input beat is credited to an older open frame if one exists. Otherwise it counts as an orphan; the engine's latency guarantees this does not occur.
- Reset: both FIFOs empty, counters 0, FSM IDLE, and all outputs 0 (`s_axis_ready` 0 during reset, 1 from the first cycle after). Any frame in flight when reset is asserted is lost.

## Timing
- `csum_valid` at cycle T → `m_axis_valid` for the first beat of that frame at T+2 if the FSM was IDLE:
  - T+1: result FIFO write.
  - T+2: IDLE load and transition to SEND, registered output.
- SEND sustains 1 beat/cycle while `m_axis_ready` = 1. There is no bubble between back-to-back frames beyond the single IDLE cycle.
- `m_axis_*` are held stable while `m_axis_valid & !m_axis_ready`.
- Throughput: one input beat per cycle whenever the FIFOs are not full.

## Configuration
- `RX_CSUM_DROP_EN` defined: a result with status[4] (tcp_fail) or status[3] (udp_fail) set sends the FSM from IDLE to DROP instead of SEND. The frame's beats are discarded and never appear on `m_axis`.
- Undefined: DROP is not compiled. Every frame is forwarded with its status, and failure handling is left downstream.

## Test plan
- Single 3-beat TCP frame, `csum_valid` at 5 cycles after last with csum 0x0000, status 5'b00101, `m_axis_ready`=1 → 3 beats out starting 2 cycles after `csum_valid`, `m_axis_status`=5'b00101 on all beats, data bit-exact.
- 8 back-to-back 2-beat frames with results delayed 6 cycles and `m_axis_ready` held 0 → `s_axis_ready` drops after the 8th frame; on release, frames emerge in order with matching csum values 0x0001..0x0008.
- Frame with status 5'b10101 (tcp_fail): with `RX_CSUM_DROP_EN` → no output beats, the next frame follows normally; without it → frame forwarded with `m_axis_status`=5'b10101.
- Random `m_axis_ready` (50%) over 100 random-length frames (1–48 beats) → output stream equals input stream; sideband constant within each frame.
- `csum_valid` pulsed with no frame in flight → `orphan_err`=1 and no output; `rst`=1 for one cycle mid-frame → all outputs 0 next cycle and `orphan_err` cleared; a new frame after reset passes cleanly.
